// File: rtl/rf_2r_1w_param.sv
// Parametrised register file: two registered read ports, one write port, write-first bypass,
// and a hardware clear sequencer that fills every entry with CLEAR_VALUE after reset or on request.
module rf_2r_1w_param #(
    parameter int unsigned      WIDTH       = 32,
    parameter int unsigned      ADDR_BITS   = 5,
    parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                 rf_clock,
    input  logic                 rf_reset,
    input  logic                 rf_clear,
    output logic                 rf_busy,
    input  logic [ADDR_BITS-1:0] rf_rd_addr_0,
    output logic [WIDTH-1:0]     rf_rd_data_0,
    input  logic [ADDR_BITS-1:0] rf_rd_addr_1,
    output logic [WIDTH-1:0]     rf_rd_data_1,
    input  logic                 rf_wr_enable,
    input  logic [ADDR_BITS-1:0] rf_wr_addr,
    input  logic [WIDTH-1:0]     rf_wr_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_BITS;

    typedef enum logic {StClear, StIdle} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]       rd_data_0_q, rd_data_0_d;
    logic [WIDTH-1:0]       rd_data_1_q, rd_data_1_d;

    logic [WIDTH-1:0]       mem [DEPTH];

    logic                   clearing;
    logic                   wr_accept;
    logic                   mem_we;
    logic [ADDR_BITS-1:0]   mem_waddr;
    logic [WIDTH-1:0]       mem_wdata;

    always_comb begin
        // A clear request masks external writes and hides stored contents on the same edge.
        clearing  = (state_q == StClear) || rf_clear;
        wr_accept = rf_wr_enable && !clearing;

        state_d   = state_q;
        cnt_d     = cnt_q;
        mem_we    = 1'b0;
        mem_waddr = rf_wr_addr;
        mem_wdata = rf_wr_data;

        if (state_q == StClear) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = CLEAR_VALUE;
            if (rf_clear) begin
                cnt_d = '0;
            end else if (&cnt_q) begin
                state_d = StIdle;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (rf_clear) begin
            state_d = StClear;
            cnt_d   = '0;
        end else begin
            mem_we = wr_accept;
        end

        if (clearing) begin
            rd_data_0_d = CLEAR_VALUE;
        end else if (wr_accept && (rf_wr_addr == rf_rd_addr_0)) begin
            rd_data_0_d = rf_wr_data;
        end else begin
            rd_data_0_d = mem[rf_rd_addr_0];
        end

        if (clearing) begin
            rd_data_1_d = CLEAR_VALUE;
        end else if (wr_accept && (rf_wr_addr == rf_rd_addr_1)) begin
            rd_data_1_d = rf_wr_data;
        end else begin
            rd_data_1_d = mem[rf_rd_addr_1];
        end
    end

    always_ff @(posedge rf_clock or negedge rf_reset) begin
        if (!rf_reset) begin
            state_q     <= StClear;
            cnt_q       <= '0;
            rd_data_0_q <= '0;
            rd_data_1_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_data_0_q <= rd_data_0_d;
            rd_data_1_q <= rd_data_1_d;
        end
    end

    // Storage is deliberately unreset so it can map onto RAM primitives.
    always_ff @(posedge rf_clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign rf_busy      = (state_q == StClear);
    assign rf_rd_data_0 = rd_data_0_q;
    assign rf_rd_data_1 = rd_data_1_q;

endmodule

// File: tb/tb_rf_2r_1w_param.sv
// Self-checking bench for rf_2r_1w_param: randomized traffic against a behavioural model of the
// register file plus directed clear, bypass and reset scenarios.
module tb_rf_2r_1w_param;

    localparam int unsigned DEPTH = 32;
    localparam logic [31:0] CV    = 32'hDEADBEEF;

    logic        rf_clock = 1'b0;
    logic        rf_reset;
    logic        clr;
    logic        busy;
    logic [4:0]  ra0, ra1, wa;
    logic [31:0] rd0, rd1, wd;
    logic        we;

    rf_2r_1w_param #(
        .WIDTH       (32),
        .ADDR_BITS   (5),
        .CLEAR_VALUE (CV)
    ) dut (
        .rf_clock     (rf_clock),
        .rf_reset     (rf_reset),
        .rf_clear     (clr),
        .rf_busy      (busy),
        .rf_rd_addr_0 (ra0),
        .rf_rd_data_0 (rd0),
        .rf_rd_addr_1 (ra1),
        .rf_rd_data_1 (rd1),
        .rf_wr_enable (we),
        .rf_wr_addr   (wa),
        .rf_wr_data   (wd)
    );

    always #5 rf_clock = ~rf_clock;

    // Behavioural model: contents plus number of edges the file stays unavailable.
    logic [31:0] model [DEPTH];
    int          busy_left;
    logic [31:0] exp0, exp1;
    logic        exp_busy;
    int          total = 0;
    int          bad   = 0;

    task automatic model_reset();
        busy_left = DEPTH;
        for (int i = 0; i < DEPTH; i++) model[i] = CV;
    endtask

    // One clock edge with the currently driven inputs; clr/we are pulses.
    task automatic cycle();
        bit unavailable;
        unavailable = (busy_left > 0) || (clr === 1'b1);
        exp0 = unavailable ? CV : (we && wa == ra0) ? wd : model[ra0];
        exp1 = unavailable ? CV : (we && wa == ra1) ? wd : model[ra1];
        if (clr) begin
            busy_left = DEPTH;
            for (int i = 0; i < DEPTH; i++) model[i] = CV;
        end else if (busy_left > 0) begin
            busy_left--;
        end else if (we) begin
            model[wa] = wd;
        end
        exp_busy = (busy_left > 0);
        @(posedge rf_clock);
        #1;
        clr = 1'b0;
        we  = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        rf_reset = 1'b0;
        clr = 0; we = 0; wa = 0; wd = 0; ra0 = 0; ra1 = 0;
        model_reset();
        #12;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b want=1", busy); end
        total++; if (rd0 !== 32'h0) begin bad++; $display("FAIL reset_rd0 got=%h want=0", rd0); end
        total++; if (rd1 !== 32'h0) begin bad++; $display("FAIL reset_rd1 got=%h want=0", rd1); end
        @(posedge rf_clock); #1;
        rf_reset = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin cycle(); n++; end
        total++; if (n !== 32) begin bad++; $display("FAIL reset_busy_len got=%0d want=32", n); end
        for (int k = 0; k < 3; k++) begin
            ra0 = (k == 0) ? 5'd0 : (k == 1) ? 5'd17 : 5'd31;
            ra1 = ra0;
            cycle();
            total++;
            if (rd0 !== CV || rd1 !== CV) begin
                bad++;
                $display("FAIL init_read a=%0d got=%h/%h want=%h", ra0, rd0, rd1, CV);
            end
        end
    endtask

    task automatic test_write_read();
        we = 1; wa = 5'd5; wd = 32'h12345678; ra0 = 5'd0; ra1 = 5'd1;
        cycle();
        ra0 = 5'd5;
        cycle();
        total++;
        if (rd0 !== 32'h12345678) begin bad++; $display("FAIL write_read got=%h want=12345678", rd0); end
    endtask

    task automatic test_bypass();
        we = 1; wa = 5'd8; wd = 32'h0BADF00D;
        cycle();
        we = 1; wa = 5'd9; wd = 32'hA5A5A5A5; ra0 = 5'd9; ra1 = 5'd9;
        cycle();
        total++;
        if (rd0 !== 32'hA5A5A5A5 || rd1 !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL bypass_both got=%h/%h want=a5a5a5a5", rd0, rd1);
        end
        we = 1; wa = 5'd9; wd = 32'h5A5A5A5A; ra0 = 5'd9; ra1 = 5'd8;
        cycle();
        total++;
        if (rd0 !== 32'h5A5A5A5A || rd1 !== 32'h0BADF00D) begin
            bad++; $display("FAIL bypass_split got=%h/%h want=5a5a5a5a/0badf00d", rd0, rd1);
        end
    endtask

    task automatic test_clear_vs_write();
        int n;
        clr = 1; we = 1; wa = 5'd3; wd = 32'h1;
        cycle();
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == 10) begin we = 1; wa = 5'd4; wd = 32'h2; end
            cycle();
        end
        total++; if (n !== 32) begin bad++; $display("FAIL clear_busy_len got=%0d want=32", n); end
        ra0 = 5'd3; ra1 = 5'd4;
        cycle();
        total++;
        if (rd0 !== CV || rd1 !== CV) begin
            bad++; $display("FAIL clear_drops_write got=%h/%h want=%h", rd0, rd1, CV);
        end
    endtask

    task automatic test_clear_restart();
        int n;
        clr = 1;
        cycle();
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == 20) clr = 1;
            cycle();
        end
        total++; if (n !== 52) begin bad++; $display("FAIL clear_restart_len got=%0d want=52", n); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        we = 1; wa = 5'd12; wd = 32'h77;
        cycle();
        clr = 1;
        cycle();
        for (int i = 0; i < 7; i++) cycle();
        #2;
        rf_reset = 1'b0;
        #1;
        model_reset();
        total++;
        if (busy !== 1'b1 || rd0 !== 32'h0 || rd1 !== 32'h0) begin
            bad++; $display("FAIL mid_reset got=%b %h/%h want=1 0/0", busy, rd0, rd1);
        end
        @(posedge rf_clock); #1;
        rf_reset = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 200) begin cycle(); n++; end
        total++; if (n !== 32) begin bad++; $display("FAIL mid_reset_len got=%0d want=32", n); end
        ra0 = 5'd12; ra1 = 5'd0;
        cycle();
        total++;
        if (rd0 !== CV || rd1 !== CV) begin
            bad++; $display("FAIL mid_reset_read got=%h/%h want=%h", rd0, rd1, CV);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            we  = 1'($urandom_range(0, 1));
            wa  = 5'($urandom);
            wd  = $urandom;
            ra0 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            clr = ($urandom_range(0, 149) == 0);
            cycle();
            total++;
            if (rd0 !== exp0) begin bad++; $display("FAIL rand_rd0 i=%0d got=%h want=%h", i, rd0, exp0); end
            total++;
            if (rd1 !== exp1) begin bad++; $display("FAIL rand_rd1 i=%0d got=%h want=%h", i, rd1, exp1); end
            total++;
            if (busy !== exp_busy) begin
                bad++; $display("FAIL rand_busy i=%0d got=%b want=%b", i, busy, exp_busy);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_random();
        test_clear_vs_write();
        test_clear_restart();
        test_reset_mid_clear();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
